// File: rtl/edge_event_arbiter_if.sv
// rtl/edge_event_arbiter_if.sv - serialized edge-event handshake bundle
interface edge_event_arbiter_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_ch;
    logic            evt_rise;
    logic            evt_fall;

    // Producer side: the arbiter presents events
    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        output evt_fall,
        input  evt_ready
    );

    // Consumer side: interrupt/log logic accepts events
    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        input  evt_fall,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge detect with round-robin event serializer
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          a,
    edge_event_arbiter_if.master  evt,
    output logic [N-1:0]          ovf,
    input  logic [N-1:0]          ovf_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_d_q;
    logic [N-1:0]    pr_q, pr_d;
    logic [N-1:0]    pf_q, pf_d;
    logic [N-1:0]    ovf_q, ovf_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] evt_ch_q;
    logic            evt_rise_q;
    logic            evt_fall_q;

    logic [N-1:0]    rise_det;
    logic [N-1:0]    fall_det;
    logic [N-1:0]    req;
    logic            any_req;
    logic [2*N-1:0]  req_sh;
    logic [N-1:0]    req_rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   grant_sum;
    logic [ID_W-1:0] grant;
    logic            load_en;
    logic [N-1:0]    clr;
    logic [N-1:0]    ovf_set;

    assign rise_det = a & ~a_d_q;
    assign fall_det = ~a & a_d_q;
    assign req      = pr_q | pf_q;
    assign any_req  = |req;

    // Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest
    // set bit, then rotate the offset back into a channel index.
    always_comb begin
        req_sh  = {req, req} >> ptr_q;
        req_rot = req_sh[N-1:0];
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = ID_W'(i);
            end
        end
        grant_sum = {1'b0, ptr_q} + {1'b0, off};
        if (grant_sum >= (ID_W+1)'(N)) begin
            grant_sum = grant_sum - (ID_W+1)'(N);
        end
        grant = grant_sum[ID_W-1:0];
    end

    // FSM next state: a load happens whenever the output slot is free or being
    // accepted this cycle and someone is requesting.
    always_comb begin
        state_d       = state_q;
        load_en       = 1'b0;
        evt.evt_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    load_en = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                evt.evt_valid = 1'b1;
                if (evt.evt_ready) begin
                    if (any_req) begin
                        load_en = 1'b1;
                        state_d = SHOW;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending flags, overflow and pointer next-state; a detection in the same
    // cycle as the load-clear leaves the flag set so no edge is dropped.
    always_comb begin
        clr     = load_en ? (N'(1) << grant) : '0;
        pr_d    = (pr_q & ~clr) | rise_det;
        pf_d    = (pf_q & ~clr) | fall_det;
        ovf_set = (rise_det & pr_q & ~clr) | (fall_det & pf_q & ~clr);
        ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
        ptr_d   = ptr_q;
        if (load_en) begin
            ptr_d = (grant == ID_W'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    // State, flags and output register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_d_q      <= '0;
            pr_q       <= '0;
            pf_q       <= '0;
            ovf_q      <= '0;
            ptr_q      <= '0;
            evt_ch_q   <= '0;
            evt_rise_q <= 1'b0;
            evt_fall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_d_q   <= a;
            pr_q    <= pr_d;
            pf_q    <= pf_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            if (load_en) begin
                evt_ch_q   <= grant;
                evt_rise_q <= pr_q[grant];
                evt_fall_q <= pf_q[grant];
            end
        end
    end

    assign evt.evt_ch   = evt_ch_q;
    assign evt.evt_rise = evt_rise_q;
    assign evt.evt_fall = evt_fall_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed scoreboard bench for edge_event_arbiter
module tb_edge_event_arbiter;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
        logic       fall;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'b0000;
    logic [3:0] ovf;
    logic [3:0] ovf_clr = 4'b0000;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_xfer   = 0;
    evt_t sb[$];
    int   xfer_cyc[$];
    logic prev_stall = 1'b0;
    evt_t prev_payload;
    evt_t got;
    evt_t exp_e;
    int   saved;

    edge_event_arbiter_if #(.ID_W(2)) evt_if ();

    edge_event_arbiter #(.N(4), .ID_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .evt     (evt_if),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic r, input logic f);
        evt_t e;
        e.ch   = ch;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && sb.size() != 0; k++) step(1);
        step(2);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: sampled on the falling edge, pops the scoreboard on transfers
    always @(negedge clk) begin
        got.ch   = evt_if.evt_ch;
        got.rise = evt_if.evt_rise;
        got.fall = evt_if.evt_fall;
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(evt_if.evt_valid), 32'd1);
                check("hold_payload", 32'(got), 32'(prev_payload));
            end
            if (evt_if.evt_valid) check("rise_or_fall", 32'(got.rise | got.fall), 32'd1);
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                check("event_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("event_payload", 32'(got), 32'(exp_e));
                end
                xfer_cyc.push_back(cyc);
                n_xfer++;
            end
            prev_stall   = evt_if.evt_valid && !evt_if.evt_ready;
            prev_payload = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        evt_if.evt_ready = 1'b0;
        step(2);
        check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("rst_ch",    32'(evt_if.evt_ch),    32'd0);
        check("rst_rise",  32'(evt_if.evt_rise),  32'd0);
        check("rst_fall",  32'(evt_if.evt_fall),  32'd0);
        check("rst_ovf",   32'(ovf),              32'd0);
        rst = 1'b0;
        step(2);
        check("idle_valid", 32'(evt_if.evt_valid), 32'd0);

        // Pulse on channel 2: rise event then fall event
        evt_if.evt_ready = 1'b1;
        push(2'd2, 1'b1, 1'b0);
        a[2] = 1'b1;
        step(3);
        push(2'd2, 1'b0, 1'b1);
        a[2] = 1'b0;
        drain("drain_pulse");
        check("pulse_ovf", 32'(ovf), 32'd0);

        // Round-robin from ptr=0: rises then falls on channels 0,1,3
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        xfer_cyc.delete();
        push(2'd0, 1'b1, 1'b0);
        push(2'd1, 1'b1, 1'b0);
        push(2'd3, 1'b1, 1'b0);
        a = 4'b1011;
        drain("drain_rr_rise");
        check("rr_count", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) check("rr_no_bubble", 32'(xfer_cyc[2] - xfer_cyc[0]), 32'd2);
        push(2'd0, 1'b0, 1'b1);
        push(2'd1, 1'b0, 1'b1);
        push(2'd3, 1'b0, 1'b1);
        a = 4'b0000;
        drain("drain_rr_fall");

        // Backpressure on channel 1
        evt_if.evt_ready = 1'b0;
        push(2'd1, 1'b1, 1'b0);
        a[1] = 1'b1;
        step(5);
        check("bp_valid", 32'(evt_if.evt_valid), 32'd1);
        check("bp_ch",    32'(evt_if.evt_ch),    32'd1);
        check("bp_rise",  32'(evt_if.evt_rise),  32'd1);
        evt_if.evt_ready = 1'b1;
        step(1);
        check("bp_after_xfer_valid", 32'(evt_if.evt_valid), 32'd0);
        push(2'd1, 1'b0, 1'b1);
        a[1] = 1'b0;
        drain("drain_bp");

        // Overflow on channel 3 while channel 0 is held
        evt_if.evt_ready = 1'b0;
        push(2'd0, 1'b1, 1'b0);
        a[0] = 1'b1;
        step(3);
        a[3] = 1'b1;
        step(1);
        a[3] = 1'b0;
        step(1);
        check("ovf_before_second_rise", 32'(ovf), 32'd0);
        a[3] = 1'b1;
        step(1);
        check("ovf_second_rise", 32'(ovf), 32'h8);
        push(2'd3, 1'b1, 1'b1);
        evt_if.evt_ready = 1'b1;
        drain("drain_ovf");
        ovf_clr = 4'b1000;
        step(1);
        ovf_clr = 4'b0000;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Overflow arriving together with ovf_clr keeps the flag
        evt_if.evt_ready = 1'b0;
        push(2'd3, 1'b0, 1'b1);
        a[3] = 1'b0;
        step(1);
        push(2'd3, 1'b1, 1'b1);
        a[3] = 1'b1;
        step(1);
        a[3] = 1'b0;
        step(1);
        a[3] = 1'b1;
        ovf_clr = 4'b1000;
        step(1);
        ovf_clr = 4'b0000;
        check("ovf_set_wins", 32'(ovf), 32'h8);
        evt_if.evt_ready = 1'b1;
        drain("drain_ovf_clr");
        ovf_clr = 4'b1000;
        step(1);
        ovf_clr = 4'b0000;
        check("ovf_cleared_again", 32'(ovf), 32'd0);

        // Detection colliding with the load-clear on channel 2
        push(2'd2, 1'b1, 1'b0);
        a[2] = 1'b1;
        step(1);
        push(2'd2, 1'b0, 1'b1);
        a[2] = 1'b0;
        drain("drain_reload");
        check("reload_ovf", 32'(ovf), 32'd0);

        // Reset in the middle of a stalled handshake
        evt_if.evt_ready = 1'b0;
        a = 4'b0110;
        step(3);
        check("pre_rst_valid", 32'(evt_if.evt_valid), 32'd1);
        rst = 1'b1;
        a = 4'b0000;
        step(1);
        check("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("mid_rst_ovf",   32'(ovf),              32'd0);
        step(1);
        rst = 1'b0;
        evt_if.evt_ready = 1'b1;
        saved = n_xfer;
        step(10);
        check("post_rst_no_events", 32'(n_xfer), 32'(saved));
        check("post_rst_valid", 32'(evt_if.evt_valid), 32'd0);

        // All channels high at reset exit
        rst = 1'b1;
        a = 4'b1111;
        step(2);
        push(2'd0, 1'b1, 1'b0);
        push(2'd1, 1'b1, 1'b0);
        push(2'd2, 1'b1, 1'b0);
        push(2'd3, 1'b1, 1'b0);
        rst = 1'b0;
        drain("drain_rst_exit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event scheduler. Detects rising and falling edges on N level inputs, holds one pending-rise and one pending-fall flag per channel, and shares a single event output port between channels with round-robin arbitration over a valid/ready handshake. Sits between the synchronized level inputs and the event consumer (interrupt/log logic), replacing per-channel rise/down outputs with one serialized event stream.

## Interface
- N, default 4: number of input channels (2..16)
- ID_W, default 2: channel-ID width, equal to ceil(log2(N))

- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- a  input  N  level inputs, already synchronized to clk
- evt_valid  output  1  event present on evt_ch/evt_rise/evt_fall
- evt_ready  input  1  consumer accepts the event when high together with evt_valid
- evt_ch  output  ID_W  channel index of the presented event
- evt_rise  output  1  presented event contains a rising edge
- evt_fall  output  1  presented event contains a falling edge
- ovf  output  N  sticky per-channel overflow flags
- ovf_clr  input  N  write-1-to-clear for ovf

## Operation
- Per channel: a_d[i] <= a[i] every cycle. rise_det = a & ~a_d. fall_det = ~a & a_d.
- Pending flags pr[i] and pf[i]: set by rise_det or fall_det. Cleared when channel i is loaded into the output register. If a clear and a new detection hit the same flag in the same cycle, the flag ends set.
- Overflow: ovf[i] sets when rise_det[i] arrives while pr[i] is set and not being cleared this cycle. The same rule applies to fall_det with pf[i]. ovf_clr[i] clears ovf[i]. If set and clear happen in the same cycle, set wins.
- Request: req[i] = pr[i] | pf[i].
- Round-robin: the search starts at pointer ptr and wraps modulo N. The first requesting channel wins. After a grant, ptr <= grant+1, wrapping from N-1 to 0. ptr holds when there is no grant.
- The FSM has two states:
  - IDLE: evt_valid=0. If any req is set, load the output register and go to SHOW.
  - SHOW: evt_valid=1. If evt_ready=1 and another req is set, reload in the same cycle and stay in SHOW. If evt_ready=1 and no req is set, go to IDLE. If evt_ready=0, hold all outputs stable.
- Load: evt_ch <= grant, evt_rise <= pr[grant], evt_fall <= pf[grant], then clear pr[grant] and pf[grant]. When both flags are set, one event carries both; order is lost by design.
- A channel can only re-enter arbitration once its previous flags have been loaded. The presented channel can gain new pending flags while it is being shown.

## Timing
- Reset values:
  - a_d = 0, so a channel already high at reset exit reports a rise.
  - pr = pf = 0, ovf = 0, ptr = 0, state IDLE.
  - evt_valid = 0, evt_ch = 0, evt_rise = 0, evt_fall = 0.
- Reset mid-handshake: the presented event and all pending flags are discarded. evt_valid=0 after the reset edge regardless of evt_ready.
- Latency: a changes before edge k. The pending flag sets at edge k. evt_valid is high after edge k+1 if the output is free or being accepted at k+1.
- Throughput: one event per cycle with evt_ready held high, and no bubble between back-to-back events.
- Handshake:
  - Transfer occurs at an edge where evt_valid & evt_ready.
  - evt_valid never drops without a transfer, except on rst.
  - evt_ch, evt_rise and evt_fall are stable while evt_valid & ~evt_ready.
- evt_rise | evt_fall is always 1 when evt_valid=1.
- Worst-case wait per channel while the consumer keeps accepting: N-1 other events.

## Test plan
- Reset exit with a=4'b0000: pulse a[2] high for 3 cycles, evt_ready=1. Expect:
  - evt_valid for one cycle with evt_ch=2, evt_rise=1, evt_fall=0.
  - Then a second event with evt_ch=2, evt_rise=0, evt_fall=1.
  - ovf=0.
- Round-robin: rise a[0], a[1] and a[3] in the same cycle, ptr=0, evt_ready=1. Expect evt_ch sequence 0,1,3 on consecutive cycles, then ptr=0. Repeat with falls; expect the same order 0,1,3.
- Backpressure: evt_ready=0 for 5 cycles with a[1] rising. Expect evt_valid=1, evt_ch=1, evt_rise=1 stable throughout. Raise evt_ready; expect the transfer and evt_valid=0 on the next cycle.
- Overflow: evt_ready=0 while channel 0 is shown. Toggle a[3] as 0→1→0→1. Expect:
  - ovf[3]=1 on the second rise.
  - Pending channel 3 delivered later with evt_rise=1 and evt_fall=1.
  - Pulsing ovf_clr[3] clears ovf[3]; a new overflow in the same cycle as ovf_clr keeps ovf[3]=1.
- Same-cycle reload: with channel 2 shown and accepted, a[2] toggles in the acceptance cycle. Expect a new channel-2 event to follow, with no lost edge and no overflow.
- Mid-operation reset: assert rst while evt_valid=1 and several flags pending. Expect evt_valid=0, ovf=0 and no events after deassertion while a stays low. If a=4'b1111 at deassertion, expect four rise events in order 0,1,2,3.
